// File: rtl/fft_arb_pkg.sv
// Shared types and helpers for the FFT master-port arbiter.
// The optional grant lock is enabled with FFT_ARB_LOCK_EN.
package fft_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int unsigned ARB_MAX_REQ = 8;

   function automatic int unsigned arb_id_w(
      input int unsigned n
   );
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First requester strictly after last, wrapping modulo n.
   function automatic logic [2:0] rr_pick(
      input logic [7:0]  req,
      input logic [2:0]  last,
      input int unsigned n
   );
      logic [2:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= ARB_MAX_REQ; i++) begin
         idx = (32'(last) + i) % n;
         if (!found && i <= n && req[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fft_arb_id_fifo.sv
// Requester-ID FIFO for outstanding reads of the FFT master port.
// DEPTH must be a power of two, at least 2.
module fft_arb_id_fifo
   import fft_arb_pkg::*;
#(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [W-1:0]  mem_q [DEPTH];

   // Extra pointer bit separates full from empty on wrap.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign head  = mem_q[rptr_q[AW-1:0]];

   assign wptr_d = wptr_q + PW'(push);
   assign rptr_d = rptr_q + PW'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/fft_master_arbiter.sv
// Round-robin share of the FFT Avalon-MM master between engines.
// Define FFT_ARB_LOCK_EN to let req_lock hold the grant.
module fft_master_arbiter
   import fft_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned ADDRESSWIDTH = 32,
   parameter int unsigned DATAWIDTH    = 32,
   parameter int unsigned MAX_PENDING  = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0]      req_address,
   input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]         req_writedata,
   input  logic [NUM_REQ-1:0]                        req_write,
   input  logic [NUM_REQ-1:0]                        req_read,
   input  logic [NUM_REQ-1:0]                        req_lock,
   output logic [NUM_REQ-1:0]                        req_waitrequest,
   output logic [DATAWIDTH-1:0]                      req_readdata,
   output logic [NUM_REQ-1:0]                        req_readdatavalid,
   output logic [ADDRESSWIDTH-1:0]                   master_address,
   output logic [DATAWIDTH-1:0]                      master_writedata,
   output logic                                      master_write,
   output logic                                      master_read,
   input  logic [DATAWIDTH-1:0]                      master_readdata,
   input  logic                                      master_readdatavalid,
   input  logic                                      master_waitrequest,
   output logic                                      rdv_err
);

   localparam int unsigned ID_W = arb_id_w(NUM_REQ);

   arb_state_t    state_q, state_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [ID_W-1:0] last_q, last_d;
   logic          rdv_err_q, rdv_err_d;

   logic          busy, sel_rd, sel_wr;
   logic          gate, acc, lock, push, pop;
   logic          fifo_full, fifo_empty;
   logic [ID_W-1:0] head;

`ifdef FFT_ARB_LOCK_EN
   assign lock = req_lock[grant_q];
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign lock        = 1'b0;
`endif

   assign busy   = (state_q == ARB_BUSY);
   assign sel_rd = req_read[grant_q];
   assign sel_wr = req_write[grant_q];
   assign pop    = master_readdatavalid & ~fifo_empty;
   // A same-cycle pop frees the slot, so a full FIFO need not gate.
   assign gate   = sel_rd & fifo_full & ~pop;

   assign master_address   = req_address[grant_q];
   assign master_writedata = req_writedata[grant_q];
   assign master_write     = busy & sel_wr;
   assign master_read      = busy & sel_rd & ~gate;

   assign acc  = (master_write | master_read) & ~master_waitrequest;
   assign push = acc & master_read;

   assign req_readdata = master_readdata;
   assign rdv_err      = rdv_err_q;

   always_comb begin
      req_waitrequest = '1;
      if (busy) begin
         req_waitrequest[grant_q] = master_waitrequest | gate;
      end
   end

   always_comb begin
      req_readdatavalid = '0;
      if (pop) begin
         req_readdatavalid[head] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      rdv_err_d = rdv_err_q | (master_readdatavalid & fifo_empty);
      unique case (state_q)
         ARB_IDLE: begin
            if (|(req_read | req_write)) begin
               grant_d = ID_W'(rr_pick(8'(req_read | req_write),
                                       3'(last_q), NUM_REQ));
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (acc) begin
               last_d = grant_q;
               if (!lock) state_d = ARB_IDLE;
            end else if (!(sel_rd | sel_wr)) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         grant_q   <= '0;
         last_q    <= ID_W'(NUM_REQ - 1);
         rdv_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         rdv_err_q <= rdv_err_d;
      end
   end

   fft_arb_id_fifo #(
      .W     (ID_W),
      .DEPTH (MAX_PENDING)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (grant_q),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_fft_master_arbiter.sv
// Directed bench for fft_master_arbiter (NUM_REQ=2, depth 4).
// Table of per-cycle vectors plus hand-written corner sequences.
module tb_fft_master_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0][31:0]  req_address;
   logic [1:0][31:0]  req_writedata;
   logic [1:0]        req_write, req_read, req_lock;
   logic [1:0]        req_waitrequest;
   logic [31:0]       req_readdata;
   logic [1:0]        req_readdatavalid;
   logic [31:0]       master_address, master_writedata;
   logic              master_write, master_read;
   logic [31:0]       master_readdata;
   logic              master_readdatavalid, master_waitrequest;
   logic              rdv_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fft_master_arbiter dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_address          (req_address),
      .req_writedata        (req_writedata),
      .req_write            (req_write),
      .req_read             (req_read),
      .req_lock             (req_lock),
      .req_waitrequest      (req_waitrequest),
      .req_readdata         (req_readdata),
      .req_readdatavalid    (req_readdatavalid),
      .master_address       (master_address),
      .master_writedata     (master_writedata),
      .master_write         (master_write),
      .master_read          (master_read),
      .master_readdata      (master_readdata),
      .master_readdatavalid (master_readdatavalid),
      .master_waitrequest   (master_waitrequest),
      .rdv_err              (rdv_err)
   );

   typedef struct {
      logic [1:0]  wr;
      logic        mwait;
      logic [31:0] a0, d0, a1, d1;
      logic        emw;
      logic [31:0] ea, ed;
      logic [1:0]  ewr;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   function automatic vec_t mk(
      logic [1:0] wr, logic mwait,
      logic [31:0] a0, logic [31:0] d0,
      logic [31:0] a1, logic [31:0] d1,
      logic emw, logic [31:0] ea,
      logic [31:0] ed, logic [1:0] ewr);
      vec_t v;
      v.wr = wr; v.mwait = mwait;
      v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
      v.emw = emw; v.ea = ea; v.ed = ed; v.ewr = ewr;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_address = '0; req_writedata = '0;
      req_write = '0; req_read = '0; req_lock = '0;
      master_readdata = '0;
      master_readdatavalid = 1'b0;
      master_waitrequest = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      settle();
      chk("rst mw", 64'(master_write), 64'd0);
      chk("rst mr", 64'(master_read), 64'd0);
      chk("rst wreq", 64'(req_waitrequest), 64'h3);
      chk("rst rdv", 64'(req_readdatavalid), 64'd0);
      chk("rst err", 64'(rdv_err), 64'd0);
      tick();

      // Fairness: both write, no wait states.
      for (int k = 0; k < 2; k++) begin
         vq.push_back(mk(2'b11, 0, 32'h100, 32'hAAAA0000,
            32'h200, 32'hBBBB0001, 0, 0, 0, 2'b11));
         vq.push_back(mk(2'b11, 0, 32'h100, 32'hAAAA0000,
            32'h200, 32'hBBBB0001, 1, 32'h100,
            32'hAAAA0000, 2'b10));
         vq.push_back(mk(2'b11, 0, 32'h100, 32'hAAAA0000,
            32'h200, 32'hBBBB0001, 0, 0, 0, 2'b11));
         vq.push_back(mk(2'b11, 0, 32'h100, 32'hAAAA0000,
            32'h200, 32'hBBBB0001, 1, 32'h200,
            32'hBBBB0001, 2'b01));
      end
      // Wait states: requester 1 alone, 3 stalled cycles.
      vq.push_back(mk(2'b10, 1, 32'h100, 32'hAAAA0000,
         32'h1FF, 32'h0, 0, 0, 0, 2'b11));
      for (int k = 0; k < 3; k++)
         vq.push_back(mk(2'b10, 1, 32'h100, 32'hAAAA0000,
            32'h1FF, 32'h0, 1, 32'h1FF, 32'h0, 2'b11));
      vq.push_back(mk(2'b10, 0, 32'h100, 32'hAAAA0000,
         32'h1FF, 32'h0, 1, 32'h1FF, 32'h0, 2'b01));
      vq.push_back(mk(2'b00, 0, 32'h100, 32'hAAAA0000,
         32'h1FF, 32'h0, 0, 0, 0, 2'b11));

      foreach (vq[i]) begin
         req_write = vq[i].wr;
         master_waitrequest = vq[i].mwait;
         req_address[0] = vq[i].a0;
         req_address[1] = vq[i].a1;
         req_writedata[0] = vq[i].d0;
         req_writedata[1] = vq[i].d1;
         settle();
         chk($sformatf("vec%0d mw", i),
             64'(master_write), 64'(vq[i].emw));
         chk($sformatf("vec%0d mr", i),
             64'(master_read), 64'd0);
         chk($sformatf("vec%0d wreq", i),
             64'(req_waitrequest), 64'(vq[i].ewr));
         if (vq[i].emw) begin
            chk($sformatf("vec%0d addr", i),
                64'(master_address), 64'(vq[i].ea));
            chk($sformatf("vec%0d data", i),
                64'(master_writedata), 64'(vq[i].ed));
         end
         tick();
      end
      req_write = '0;
      master_waitrequest = 1'b0;

      // Read routing.
      req_address[0] = 32'h10;
      req_address[1] = 32'h20;
      req_read = 2'b11;
      settle(); chk("rr idle0 mr", 64'(master_read), 64'd0);
      tick();
      settle(); chk("rr g0 mr", 64'(master_read), 64'd1);
      chk("rr g0 addr", 64'(master_address), 64'h10);
      chk("rr g0 wreq", 64'(req_waitrequest), 64'h2);
      tick();
      req_read = 2'b10;
      settle(); chk("rr idle1 mr", 64'(master_read), 64'd0);
      tick();
      settle(); chk("rr g1 mr", 64'(master_read), 64'd1);
      chk("rr g1 addr", 64'(master_address), 64'h20);
      chk("rr g1 wreq", 64'(req_waitrequest), 64'h1);
      tick();
      req_read = '0;
      master_readdatavalid = 1'b1;
      master_readdata = 32'hA;
      settle(); chk("rr beat0 rdv", 64'(req_readdatavalid), 64'h1);
      chk("rr beat0 data", 64'(req_readdata), 64'hA);
      tick();
      master_readdata = 32'hB;
      settle(); chk("rr beat1 rdv", 64'(req_readdatavalid), 64'h2);
      chk("rr beat1 data", 64'(req_readdata), 64'hB);
      tick();
      master_readdatavalid = 1'b0;
      settle(); chk("rr quiet rdv", 64'(req_readdatavalid), 64'd0);
      chk("rr err", 64'(rdv_err), 64'd0);
      tick();

      // FIFO full: four reads fill it, the fifth is gated.
      req_address[0] = 32'h40;
      req_read = 2'b01;
      for (int k = 0; k < 4; k++) begin
         settle(); chk($sformatf("ff idle%0d mr", k),
                       64'(master_read), 64'd0);
         tick();
         settle(); chk($sformatf("ff rd%0d mr", k),
                       64'(master_read), 64'd1);
         tick();
      end
      settle(); chk("ff idle4 mr", 64'(master_read), 64'd0);
      tick();
      for (int k = 0; k < 2; k++) begin
         settle();
         chk($sformatf("ff gate%0d mr", k), 64'(master_read), 64'd0);
         chk($sformatf("ff gate%0d wreq", k),
             64'(req_waitrequest), 64'h3);
         tick();
      end
      master_readdatavalid = 1'b1;
      master_readdata = 32'h55;
      settle(); chk("ff pushpop mr", 64'(master_read), 64'd1);
      chk("ff pushpop wreq", 64'(req_waitrequest), 64'h2);
      chk("ff pushpop rdv", 64'(req_readdatavalid), 64'h1);
      tick();
      req_read = '0;
      for (int k = 0; k < 4; k++) begin
         master_readdata = 32'(k);
         settle(); chk($sformatf("ff drain%0d rdv", k),
                       64'(req_readdatavalid), 64'h1);
         tick();
      end
      master_readdatavalid = 1'b0;
      settle(); chk("ff err", 64'(rdv_err), 64'd0);
      tick();

      // Granted requester abandons its command mid-stall.
      req_address[0] = 32'h500;
      req_address[1] = 32'h600;
      master_waitrequest = 1'b1;
      req_write = 2'b01;
      settle(); chk("pv idle mw", 64'(master_write), 64'd0);
      tick();
      settle(); chk("pv g0 mw", 64'(master_write), 64'd1);
      chk("pv g0 addr", 64'(master_address), 64'h500);
      tick();
      req_write = 2'b10;
      settle(); chk("pv drop mw", 64'(master_write), 64'd0);
      tick();
      settle(); chk("pv idle2 mw", 64'(master_write), 64'd0);
      tick();
      settle(); chk("pv g1 mw", 64'(master_write), 64'd1);
      chk("pv g1 addr", 64'(master_address), 64'h600);
      tick();
      master_waitrequest = 1'b0;
      settle(); chk("pv g1 wreq", 64'(req_waitrequest), 64'h1);
      tick();
      req_write = '0;
      tick();

      // Lock behaviour.
      do_reset();
      req_address[0] = 32'h300;
      req_address[1] = 32'h400;
      req_write = 2'b11;
      req_lock = 2'b01;
      settle(); chk("lk idle mw", 64'(master_write), 64'd0);
      tick();
`ifdef FFT_ARB_LOCK_EN
      for (int k = 0; k < 3; k++) begin
         if (k == 2) req_lock = 2'b00;
         settle();
         chk($sformatf("lk x%0d mw", k), 64'(master_write), 64'd1);
         chk($sformatf("lk x%0d addr", k),
             64'(master_address), 64'h300);
         chk($sformatf("lk x%0d wreq", k),
             64'(req_waitrequest), 64'h2);
         tick();
      end
`else
      settle(); chk("lk x0 mw", 64'(master_write), 64'd1);
      chk("lk x0 addr", 64'(master_address), 64'h300);
      tick();
`endif
      settle(); chk("lk bubble mw", 64'(master_write), 64'd0);
      tick();
      settle(); chk("lk g1 mw", 64'(master_write), 64'd1);
      chk("lk g1 addr", 64'(master_address), 64'h400);
      chk("lk g1 wreq", 64'(req_waitrequest), 64'h1);
      tick();
      req_write = '0;
      req_lock = '0;
      tick();

      // Reset with reads pending, then a stray beat.
      do_reset();
      req_read = 2'b01;
      tick();
      settle(); chk("st rd0 mr", 64'(master_read), 64'd1);
      tick();
      req_read = 2'b10;
      tick();
      settle(); chk("st rd1 mr", 64'(master_read), 64'd1);
      tick();
      req_read = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle(); chk("st rst err", 64'(rdv_err), 64'd0);
      tick();
      master_readdatavalid = 1'b1;
      settle(); chk("st stray rdv", 64'(req_readdatavalid), 64'd0);
      tick();
      master_readdatavalid = 1'b0;
      settle(); chk("st err set", 64'(rdv_err), 64'd1);
      tick();
      settle(); chk("st err sticky", 64'(rdv_err), 64'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
